seq_multiplier: RTL



---
 rtl/seq_multiplier.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
//   Iterative radix-2 shift-add multiplier. One multiplier bit is consumed per
//   clock, so a WIDTH x WIDTH product takes WIDTH iterations plus one cycle
//   for the sign fix-up. Signed operands are multiplied as magnitudes, and
//   the sign is applied to the full 2*WIDTH-bit result at the end.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous, active-high reset (priority over everything)
//   start        request, only sampled while idle
//   signed_mode  1 = two's-complement operands, 0 = unsigned (captured w/ start)
//   a            multiplicand (captured with start)
//   b            multiplier   (captured with start)
//   busy         high while iterating and during the fix-up cycle
//   done         one-cycle pulse in the cycle lo/hi first show a new product
//   lo           product bits [WIDTH-1:0]
//   hi           product bits [2*WIDTH-1:WIDTH]
//
// Timing: start sampled at edge 0, iterations at edges 1..WIDTH, result
// registered at edge WIDTH+1 (done high in the following cycle). The engine
// is already idle while done is high, so a new start is accepted then.
// -----------------------------------------------------------------------------
module seq_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int PROD_W = 2 * WIDTH;

  localparam logic [WIDTH-1:0]  ONE_W    = WIDTH'(1);
  localparam logic [PROD_W-1:0] ONE_P    = PROD_W'(1);
  localparam logic [CNT_W-1:0]  ONE_C    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  // Elaboration-time guard on the parameter set.
  if (WIDTH < 2 || (2 ** CNT_W) <= WIDTH) begin : g_bad_param
    $error("seq_multiplier: need WIDTH >= 2 and 2**CNT_W > WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0]  cnt;
  logic [WIDTH-1:0]  mag_b;     // multiplier magnitude, shifted right per step
  logic [PROD_W-1:0] mag_a_sh;  // multiplicand magnitude << cnt
  logic [PROD_W-1:0] acc;       // running magnitude of the product
  logic              neg;       // final product must be negated

  logic              last_iter;

  // Magnitude of an operand. The most negative value maps onto itself,
  // which is still correct when read as an unsigned WIDTH-bit number.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             sm);
    if (sm && v[WIDTH-1]) begin
      return ~v + ONE_W;
    end
    return v;
  endfunction

  // Apply the product sign to the accumulated magnitude (modulo 2**PROD_W).
  function automatic logic [PROD_W-1:0] apply_sign(input logic [PROD_W-1:0] m,
                                                   input logic              n);
    if (n) begin
      return ~m + ONE_P;
    end
    return m;
  endfunction

  assign last_iter = (cnt == LAST_CNT);

  // ---------------------------------------------------------------------------
  // Control: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Control: next state and busy
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) begin
          state_nx = FIX;
        end
      end
      FIX: begin
        busy     = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: capture, shift-add iterations, sign fix-up
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      mag_b    <= '0;
      mag_a_sh <= '0;
      acc      <= '0;
      neg      <= 1'b0;
      done     <= 1'b0;
      lo       <= '0;
      hi       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mag_a_sh <= {{WIDTH{1'b0}}, magnitude(a, signed_mode)};
            mag_b    <= magnitude(b, signed_mode);
            neg      <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc      <= '0;
            cnt      <= '0;
          end
        end
        RUN: begin
          // mag_a_sh tracks mag_a << cnt, so no barrel shifter is needed.
          if (mag_b[0]) begin
            acc <= acc + mag_a_sh;
          end
          mag_a_sh <= mag_a_sh << 1;
          mag_b    <= mag_b >> 1;
          cnt      <= cnt + ONE_C;
        end
        FIX: begin
          {hi, lo} <= apply_sign(acc, neg);
          done     <= 1'b1;
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule
